op_identifier: RTL and testbench



---
 rtl/opid_pkg.sv | 23 ++
 rtl/opid_decode.sv | 26 ++
 rtl/op_identifier.sv | 121 ++++++++++++
 tb/tb_op_identifier.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/opid_pkg.sv
// Shared constants and state encoding for the op_identifier block.
// Key codes and truth tables use bit index == stimulus vector index.
package opid_pkg;

  localparam logic [1:0] KEY_OR   = 2'b00;
  localparam logic [1:0] KEY_NOR  = 2'b01;
  localparam logic [1:0] KEY_XOR  = 2'b10;
  localparam logic [1:0] KEY_XNOR = 2'b11;

  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DECIDE,
    DONE
  } state_t;

endpackage

// File: rtl/opid_decode.sv
// Combinational truth-table decoder: maps a captured 4-entry table to {valid, key}.
// Unrecognised tables report valid=0 with key forced to the or code.
module opid_decode
  import opid_pkg::*;
(
  input  logic [3:0] tt,
  output logic       valid,
  output logic [1:0] key
);

  always_comb begin
    valid = 1'b1;
    key   = KEY_OR;
    case (tt)
      TT_OR:   key = KEY_OR;
      TT_NOR:  key = KEY_NOR;
      TT_XOR:  key = KEY_XOR;
      TT_XNOR: key = KEY_XNOR;
      default: begin
        valid = 1'b0;
        key   = KEY_OR;
      end
    endcase
  end

endmodule

// File: rtl/op_identifier.sv
// Sweeps (x,y) through 00,01,10,11 into an unknown 2-input logic unit and identifies its key.
// Optional macro OPID_CONFIRM_EN runs the sweep twice and requires both tables to agree.
module op_identifier
  import opid_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       x,
  output logic       y,
  input  logic       r,
  output logic       busy,
  output logic       done,
  output logic       valid,
  output logic [0:1] key
);

  localparam bit         NO_WAIT   = (SETTLE == 0);
  localparam logic [3:0] WAIT_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  state_t     state, next_state;
  logic [1:0] idx;
  logic [3:0] wait_cnt;
  logic [3:0] tt;
  logic       last_pass;
  logic       dec_valid;
  logic [1:0] dec_key;
  logic       match;

`ifdef OPID_CONFIRM_EN
  logic       pass;
  logic [3:0] tt_a;
  assign last_pass = pass;
  assign match     = dec_valid && (tt == tt_a);
`else
  assign last_pass = 1'b1;
  assign match     = dec_valid;
`endif

  opid_decode u_decode (
    .tt    (tt),
    .valid (dec_valid),
    .key   (dec_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // With SETTLE=0 the DRIVE state is skipped so each vector lasts a single SAMPLE cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = NO_WAIT ? SAMPLE : DRIVE;
      DRIVE:   if (wait_cnt == WAIT_LAST) next_state = SAMPLE;
      SAMPLE: begin
        if (idx == 2'd3 && last_pass) next_state = DECIDE;
        else                          next_state = NO_WAIT ? SAMPLE : DRIVE;
      end
      DECIDE:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= 2'd0;
      wait_cnt <= 4'd0;
      tt       <= 4'd0;
      valid    <= 1'b0;
      key      <= 2'b00;
`ifdef OPID_CONFIRM_EN
      pass     <= 1'b0;
      tt_a     <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx      <= 2'd0;
            wait_cnt <= 4'd0;
            tt       <= 4'd0;
`ifdef OPID_CONFIRM_EN
            pass     <= 1'b0;
`endif
          end
        end
        DRIVE: wait_cnt <= (wait_cnt == WAIT_LAST) ? 4'd0 : wait_cnt + 4'd1;
        SAMPLE: begin
          tt[idx]  <= r;
          idx      <= idx + 2'd1;
          wait_cnt <= 4'd0;
`ifdef OPID_CONFIRM_EN
          if (idx == 2'd3 && !pass) begin
            pass <= 1'b1;
            tt_a <= {r, tt[2:0]};
          end
`endif
        end
        DECIDE: begin
          valid <= match;
          key   <= match ? dec_key : KEY_OR;
        end
        default: ;
      endcase
    end
  end

  // idx wraps to 0 after the last vector, so x/y fall back to 00 outside the sweep.
  always_comb begin
    busy = (state == DRIVE) || (state == SAMPLE) || (state == DECIDE);
    done = (state == DONE);
    x    = ((state == DRIVE) || (state == SAMPLE)) & idx[1];
    y    = ((state == DRIVE) || (state == SAMPLE)) & idx[0];
  end

endmodule

// File: tb/tb_op_identifier.sv
// Directed bench for op_identifier: two instances (SETTLE=1 and SETTLE=3) driving a modelled logic unit.
// Builds with or without OPID_CONFIRM_EN; sweep latency expectations follow the build.
module tb_op_identifier;

`ifdef OPID_CONFIRM_EN
  localparam int SWEEPS = 2;
`else
  localparam int SWEEPS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, start3;
  logic       x1, y1, r1, busy1, done1, valid1;
  logic       x3, y3, r3, busy3, done3, valid3;
  logic [0:1] key1, key3;
  logic       flip3;
  int         op1, op3;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  // op: 0=or 1=nor 2=xor 3=xnor, anything else ties the response low
  function automatic logic unit(input int op, input logic a, input logic b);
    case (op)
      0:       return a | b;
      1:       return ~(a | b);
      2:       return a ^ b;
      3:       return ~(a ^ b);
      default: return 1'b0;
    endcase
  endfunction

  assign r1 = unit(op1, x1, y1);
  assign r3 = unit(op3, x3, y3) ^ flip3;

  op_identifier #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .x(x1), .y(y1), .r(r1),
    .busy(busy1), .done(done1), .valid(valid1), .key(key1)
  );

  op_identifier #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .x(x3), .y(y3), .r(r3),
    .busy(busy3), .done(done3), .valid(valid3), .key(key3)
  );

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // d=0 selects the SETTLE=1 instance, d=1 the SETTLE=3 instance
  task automatic run_sweep(input int d, input int op, input logic [1:0] ekey, input logic evalid,
                           input bit flip_second, input bit restart);
    int per, vec, lat;
    logic [1:0] exy;
    logic       ebusy;
    per = d ? 4 : 2;
    vec = SWEEPS * 4 * per;
    lat = vec + 1;
    if (d) op3 = op; else op1 = op;
    @(negedge clk);
    if (d) start3 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    if (d) start3 = 1'b0; else start1 = 1'b0;
    for (int c = 0; c <= lat + 1; c++) begin
      if (c < vec) begin
        exy   = 2'((c / per) % 4);
        ebusy = 1'b1;
      end else begin
        exy   = 2'b00;
        ebusy = (c < lat);
      end
      if (d) begin
        check($sformatf("xy3 op=%0d c=%0d", op, c), {x3, y3}, exy);
        check($sformatf("busy3 op=%0d c=%0d", op, c), {1'b0, busy3}, {1'b0, ebusy});
        check($sformatf("done3 op=%0d c=%0d", op, c), {1'b0, done3}, {1'b0, c == lat});
        if (c == lat) begin
          check($sformatf("key3 op=%0d", op), key3, ekey);
          check($sformatf("valid3 op=%0d", op), {1'b0, valid3}, {1'b0, evalid});
        end
      end else begin
        check($sformatf("xy1 op=%0d c=%0d", op, c), {x1, y1}, exy);
        check($sformatf("busy1 op=%0d c=%0d", op, c), {1'b0, busy1}, {1'b0, ebusy});
        check($sformatf("done1 op=%0d c=%0d", op, c), {1'b0, done1}, {1'b0, c == lat});
        if (c == lat) begin
          check($sformatf("key1 op=%0d", op), key1, ekey);
          check($sformatf("valid1 op=%0d", op), {1'b0, valid1}, {1'b0, evalid});
        end
      end
      if (restart) start1 = (c == 2);
      if (flip_second) flip3 = (c >= 4 * per) && (c < 8 * per);
      @(negedge clk);
    end
    start1 = 1'b0;
    flip3  = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    flip3  = 1'b0;
    op1    = 0;
    op3    = 2;
    #3;
    check("rst xy1", {x1, y1}, 2'b00);
    check("rst busy1", {1'b0, busy1}, 2'b00);
    check("rst done1", {1'b0, done1}, 2'b00);
    check("rst valid1", {1'b0, valid1}, 2'b00);
    check("rst key1", key1, 2'b00);
    check("rst busy3", {1'b0, busy3}, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_sweep(0, 0, 2'b00, 1'b1, 1'b0, 1'b0);
    run_sweep(0, 1, 2'b01, 1'b1, 1'b0, 1'b0);
    run_sweep(0, 2, 2'b10, 1'b1, 1'b0, 1'b0);
    run_sweep(0, 3, 2'b11, 1'b1, 1'b0, 1'b0);
    run_sweep(0, 4, 2'b00, 1'b0, 1'b0, 1'b0);
    run_sweep(0, 0, 2'b00, 1'b1, 1'b0, 1'b1);
    run_sweep(0, 3, 2'b11, 1'b1, 1'b0, 1'b0);

    // abort a sweep five cycles in; previous result was xnor/valid so reset values are visible
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (5) @(negedge clk);
    check("pre-abort xy1", {x1, y1}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check("abort xy1", {x1, y1}, 2'b00);
    check("abort busy1", {1'b0, busy1}, 2'b00);
    check("abort done1", {1'b0, done1}, 2'b00);
    check("abort valid1", {1'b0, valid1}, 2'b00);
    check("abort key1", key1, 2'b00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort hold done1 k=%0d", k), {1'b0, done1}, 2'b00);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("post-abort done1 k=%0d", k), {1'b0, done1}, 2'b00);
    end
    run_sweep(0, 2, 2'b10, 1'b1, 1'b0, 1'b0);

    run_sweep(1, 2, 2'b10, 1'b1, 1'b0, 1'b0);
`ifdef OPID_CONFIRM_EN
    run_sweep(1, 2, 2'b00, 1'b0, 1'b1, 1'b0);
    run_sweep(1, 2, 2'b10, 1'b1, 1'b0, 1'b0);
`else
    run_sweep(1, 1, 2'b01, 1'b1, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
